// File: rtl/matmul_result_collector_if.sv
// Handshake bundle: tagged product stream into the collector, rescaled row-major drain stream out.
interface matmul_result_collector_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH + 2
);
    logic signed [ACC_WIDTH-1:0] c_in;
    logic                        c_valid;
    logic [1:0]                  c_row;
    logic [1:0]                  c_col;
    logic                        done_in;
    logic [DATA_WIDTH-1:0]       m_data;
    logic                        m_valid;
    logic                        m_ready;
    logic [3:0]                  m_index;
    logic                        m_last;

    modport master (
        output c_in, c_valid, c_row, c_col, done_in, m_ready,
        input  m_data, m_valid, m_index, m_last
    );

    modport slave (
        input  c_in, c_valid, c_row, c_col, done_in, m_ready,
        output m_data, m_valid, m_index, m_last
    );
endinterface

// File: rtl/matmul_result_collector.sv
// Collects tagged full-precision products into an M x P buffer, rescaling each with round/saturate,
// then drains the finished matrix in row-major order over a valid/ready stream.
module matmul_result_collector #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16,
    parameter int M          = 3,
    parameter int P          = 3,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH + 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    matmul_result_collector_if.slave bus,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     sat_flag,
    output logic                     err_overrun,
    output logic                     err_incomplete
);
    localparam int         N        = M * P;
    localparam logic [3:0] LAST_IDX = 4'(N - 1);
    localparam logic signed [ACC_WIDTH:0] HALF_LSB = (ACC_WIDTH + 1)'(1) << (FRAC_BITS - 1);

    typedef enum logic {S_COLLECT, S_DRAIN} state_t;

    state_t                state;
    logic [N-1:0]          mask;
    logic [3:0]            ptr;
    logic [DATA_WIDTH-1:0] buffer [N];

    // One extra bit of headroom keeps the rounding add from wrapping at the top of the range.
    logic signed [ACC_WIDTH:0]         rounded;
    logic signed [ACC_WIDTH:0]         shifted;
    logic [ACC_WIDTH-DATA_WIDTH+1:0]   top_bits;
    logic                              fits;
    logic [DATA_WIDTH-1:0]             scaled;

    assign rounded  = {bus.c_in[ACC_WIDTH-1], bus.c_in} + HALF_LSB;
    assign shifted  = rounded >>> FRAC_BITS;
    assign top_bits = shifted[ACC_WIDTH:DATA_WIDTH-1];
    assign fits     = (&top_bits) | ~(|top_bits);
    assign scaled   = fits ? shifted[DATA_WIDTH-1:0]
                    : shifted[ACC_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                    :                      {1'b0, {(DATA_WIDTH-1){1'b1}}};

    logic                  in_range;
    logic [3:0]            wr_idx;
    logic                  wr_en;
    logic [N-1:0]          mask_next;
    logic [DATA_WIDTH-1:0] first_elem;
    logic [3:0]            ptr_inc;

    assign in_range  = (32'(bus.c_row) < M) && (32'(bus.c_col) < P);
    assign wr_idx    = 4'(bus.c_row) * 4'(P) + 4'(bus.c_col);
    assign wr_en     = !clr && (state == S_COLLECT) && bus.c_valid && in_range;
    assign mask_next = mask | (wr_en ? (N'(1) << wr_idx) : '0);
    // Element 0 may be written on the same edge that starts the drain, so bypass the buffer.
    assign first_elem = (wr_en && wr_idx == 4'd0) ? scaled : buffer[0];
    assign ptr_inc    = ptr + 4'd1;

    // NOTE: the buffer has no reset; a drain only starts once every entry was written this frame.
    always_ff @(posedge clk) begin
        if (wr_en) buffer[wr_idx] <= scaled;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_COLLECT;
            mask           <= '0;
            ptr            <= '0;
            bus.m_data     <= '0;
            bus.m_valid    <= 1'b0;
            bus.m_index    <= '0;
            bus.m_last     <= 1'b0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            sat_flag       <= 1'b0;
            err_overrun    <= 1'b0;
            err_incomplete <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (clr) begin
                state          <= S_COLLECT;
                mask           <= '0;
                ptr            <= '0;
                bus.m_valid    <= 1'b0;
                bus.m_index    <= '0;
                bus.m_last     <= 1'b0;
                busy           <= 1'b0;
                sat_flag       <= 1'b0;
                err_overrun    <= 1'b0;
                err_incomplete <= 1'b0;
            end else begin
                case (state)
                    S_COLLECT: begin
                        if (bus.c_valid && !in_range) err_incomplete <= 1'b1;
                        if (wr_en && !fits)           sat_flag       <= 1'b1;
                        if (bus.done_in) begin
                            if (&mask_next) begin
                                state       <= S_DRAIN;
                                busy        <= 1'b1;
                                mask        <= mask_next;
                                ptr         <= '0;
                                bus.m_valid <= 1'b1;
                                bus.m_index <= '0;
                                bus.m_last  <= (LAST_IDX == 4'd0);
                                bus.m_data  <= first_elem;
                            end else begin
                                err_incomplete <= 1'b1;
                                mask           <= '0;
                            end
                        end else begin
                            mask <= mask_next;
                        end
                    end
                    S_DRAIN: begin
                        if (bus.c_valid) err_overrun <= 1'b1;
                        if (bus.m_ready) begin
                            if (ptr == LAST_IDX) begin
                                state       <= S_COLLECT;
                                busy        <= 1'b0;
                                mask        <= '0;
                                ptr         <= '0;
                                bus.m_valid <= 1'b0;
                                bus.m_index <= '0;
                                bus.m_last  <= 1'b0;
                                frame_done  <= 1'b1;
                            end else begin
                                ptr         <= ptr_inc;
                                bus.m_index <= ptr_inc;
                                bus.m_last  <= (ptr_inc == LAST_IDX);
                                bus.m_data  <= buffer[ptr_inc];
                            end
                        end
                    end
                    default: state <= S_COLLECT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_matmul_result_collector.sv
// Bench for matmul_result_collector: table-driven frames checked through a drain scoreboard,
// plus hand-written error, abort and simultaneous-event sequences.
module tb_matmul_result_collector;
    localparam int DW = 32;
    localparam int AW = 66;
    localparam int N  = 9;

    typedef struct {
        logic signed [AW-1:0] c_in;
        logic [DW-1:0]        exp;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [3:0]    idx;
        logic          last;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic busy, frame_done, sat_flag, err_overrun, err_incomplete;

    matmul_result_collector_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus ();

    matmul_result_collector dut (
        .clk           (clk),
        .rst           (rst),
        .clr           (clr),
        .bus           (bus.slave),
        .busy          (busy),
        .frame_done    (frame_done),
        .sat_flag      (sat_flag),
        .err_overrun   (err_overrun),
        .err_incomplete(err_incomplete)
    );

    always #5 clk = ~clk;

    vec_t          vecs [27];
    sb_t           q [$];
    logic [DW-1:0] exp_buf [N];
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_m_data"},     64'(bus.m_data), 64'd0);
        check({pfx, "_m_valid"},    64'(bus.m_valid), 64'd0);
        check({pfx, "_m_index"},    64'(bus.m_index), 64'd0);
        check({pfx, "_m_last"},     64'(bus.m_last), 64'd0);
        check({pfx, "_busy"},       64'(busy), 64'd0);
        check({pfx, "_frame_done"}, 64'(frame_done), 64'd0);
        check({pfx, "_sat"},        64'(sat_flag), 64'd0);
        check({pfx, "_overrun"},    64'(err_overrun), 64'd0);
        check({pfx, "_incomplete"}, 64'(err_incomplete), 64'd0);
    endtask

    task automatic wr(input int idx, input logic signed [AW-1:0] v, input logic [DW-1:0] e,
                      input bit with_done);
        bus.c_valid = 1'b1;
        bus.c_row   = 2'(idx / 3);
        bus.c_col   = 2'(idx % 3);
        bus.c_in    = v;
        bus.done_in = with_done;
        exp_buf[idx] = e;
        @(negedge clk);
        bus.c_valid = 1'b0;
        bus.done_in = 1'b0;
    endtask

    task automatic wr_rc(input logic [1:0] row, input logic [1:0] col, input logic signed [AW-1:0] v);
        bus.c_valid = 1'b1;
        bus.c_row   = row;
        bus.c_col   = col;
        bus.c_in    = v;
        @(negedge clk);
        bus.c_valid = 1'b0;
    endtask

    task automatic load_frame(input int base, input int count);
        for (int k = 0; k < count; k++) wr(k, vecs[base + k].c_in, vecs[base + k].exp, 1'b0);
    endtask

    task automatic push_frame();
        for (int k = 0; k < N; k++) q.push_back('{exp_buf[k], 4'(k), (k == N - 1)});
    endtask

    task automatic pulse_done();
        bus.done_in = 1'b1;
        @(negedge clk);
        bus.done_in = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // mode 0: always ready; mode 1: ready pattern 1,0,0 repeating
    task automatic run_drain(input int mode, input bit check_busy);
        int  busy_cnt = 0;
        int  fd_cnt   = 0;
        int  phase    = 0;
        bit  stalled  = 1'b0;
        bit  fin      = 1'b0;
        bit  ready;
        sb_t e;
        sb_t sv;
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            if (frame_done) begin
                fd_cnt++;
                fin = 1'b1;
            end
            if (busy) busy_cnt++;
            if (stalled) begin
                check("stall_data",  64'(bus.m_data), 64'(sv.data));
                check("stall_index", 64'(bus.m_index), 64'(sv.idx));
                check("stall_last",  64'(bus.m_last), 64'(sv.last));
            end
            stalled = 1'b0;
            if (bus.m_valid) begin
                ready = (mode == 0) ? 1'b1 : (phase % 3 == 0);
                phase++;
                bus.m_ready = ready;
                if (q.size() == 0) begin
                    check("unexpected_valid", 64'(bus.m_valid), 64'd0);
                end else if (ready) begin
                    e = q.pop_front();
                    check("m_data",  64'(bus.m_data), 64'(e.data));
                    check("m_index", 64'(bus.m_index), 64'(e.idx));
                    check("m_last",  64'(bus.m_last), 64'(e.last));
                end else begin
                    sv      = '{bus.m_data, bus.m_index, bus.m_last};
                    stalled = 1'b1;
                end
            end else begin
                bus.m_ready = 1'b0;
            end
            @(negedge clk);
        end
        bus.m_ready = 1'b0;
        check("drain_left", 64'(q.size()), 64'd0);
        check("frame_done_cnt", 64'(fd_cnt), 64'd1);
        if (check_busy) check("busy_cycles", 64'(busy_cnt), 64'd9);
        check("post_valid", 64'(bus.m_valid), 64'd0);
        check("post_busy", 64'(busy), 64'd0);
        check("frame_done_once", 64'(frame_done), 64'd0);
    endtask

    initial begin
        for (int k = 0; k < N; k++) vecs[k] = '{66'(k + 1) << 32, 32'(k + 1) << 16};
        vecs[9]  = '{66'sh8000, 32'h1};
        vecs[10] = '{66'sh7FFF, 32'h0};
        vecs[11] = '{-66'sh8000, 32'h0};
        vecs[12] = '{-66'sh8001, 32'hFFFF_FFFF};
        vecs[13] = '{66'sh0, 32'h0};
        vecs[14] = '{(66'sh7FFF_FFFF <<< 16) + 66'sh7FFF, 32'h7FFF_FFFF};
        vecs[15] = '{-(66'sd1 <<< 47) - 66'sh8000, 32'h8000_0000};
        vecs[16] = '{66'sh1_8000, 32'h2};
        vecs[17] = '{-66'sh1_8001, 32'hFFFF_FFFE};
        vecs[18] = '{66'sd1 <<< 50, 32'h7FFF_FFFF};
        vecs[19] = '{-(66'sd1 <<< 50), 32'h8000_0000};
        vecs[20] = '{(66'sd1 <<< 47) - 66'sd1, 32'h7FFF_FFFF};
        vecs[21] = '{-(66'sd1 <<< 47) - 66'sh8001, 32'h8000_0000};
        vecs[22] = '{~(66'sd1 <<< 65), 32'h7FFF_FFFF};
        vecs[23] = '{66'sd1 <<< 65, 32'h8000_0000};
        vecs[24] = '{66'sd5 <<< 16, 32'h5};
        vecs[25] = '{-(66'sd3 <<< 16), 32'hFFFF_FFFD};
        vecs[26] = '{66'sh7FFF_FFFF <<< 16, 32'h7FFF_FFFF};

        bus.c_in = '0; bus.c_valid = 1'b0; bus.c_row = '0; bus.c_col = '0;
        bus.done_in = 1'b0; bus.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // Identity frame, done_in the cycle after the last write.
        load_frame(0, N);
        push_frame();
        pulse_done();
        run_drain(0, 1'b1);
        check("identity_sat", 64'(sat_flag), 64'd0);

        // Rounding frame, written in reverse; element 0 lands together with done_in.
        for (int k = N - 1; k >= 1; k--) wr(k, vecs[9 + k].c_in, vecs[9 + k].exp, 1'b0);
        wr(0, vecs[9].c_in, vecs[9].exp, 1'b1);
        push_frame();
        run_drain(0, 1'b1);
        check("round_sat", 64'(sat_flag), 64'd0);
        check("round_incomplete", 64'(err_incomplete), 64'd0);

        // Saturation frame with a duplicate write to index 4, drained under backpressure.
        wr(4, 66'sd77 <<< 16, 32'd77, 1'b0);
        load_frame(18, N);
        push_frame();
        pulse_done();
        run_drain(1, 1'b0);
        check("sat_set", 64'(sat_flag), 64'd1);

        // Sat flag survives a clean frame and clears only on clr.
        load_frame(0, N);
        push_frame();
        pulse_done();
        run_drain(0, 1'b1);
        check("sat_held", 64'(sat_flag), 64'd1);
        do_clr();
        check("sat_cleared", 64'(sat_flag), 64'd0);

        // done_in after only 8 writes: flag, no drain, mask cleared.
        load_frame(0, N - 1);
        pulse_done();
        check("short_incomplete", 64'(err_incomplete), 64'd1);
        check("short_busy", 64'(busy), 64'd0);
        check("short_valid", 64'(bus.m_valid), 64'd0);
        wr(8, vecs[8].c_in, vecs[8].exp, 1'b0);
        pulse_done();
        check("mask_cleared_busy", 64'(busy), 64'd0);
        do_clr();

        // Out-of-range indices are flagged and never written; c_valid during drain is dropped.
        load_frame(0, N);
        wr_rc(2'd0, 2'd3, 66'sh1234 <<< 32);
        wr_rc(2'd3, 2'd0, 66'sh5678 <<< 32);
        check("range_incomplete", 64'(err_incomplete), 64'd1);
        push_frame();
        pulse_done();
        check("range_busy", 64'(busy), 64'd1);
        bus.m_ready = 1'b0;
        bus.c_valid = 1'b1; bus.c_row = 2'd0; bus.c_col = 2'd0; bus.c_in = 66'sh9999 <<< 32;
        bus.done_in = 1'b1;
        @(negedge clk);
        bus.c_valid = 1'b0;
        bus.done_in = 1'b0;
        check("overrun_set", 64'(err_overrun), 64'd1);
        run_drain(0, 1'b0);
        check("overrun_held", 64'(err_overrun), 64'd1);
        do_clr();
        check("clr_overrun", 64'(err_overrun), 64'd0);
        check("clr_incomplete", 64'(err_incomplete), 64'd0);

        // clr mid-drain abandons the frame and the mask.
        load_frame(0, N);
        pulse_done();
        bus.m_ready = 1'b1;
        bus.c_valid = 1'b1; bus.c_row = 2'd1; bus.c_col = 2'd1;
        @(negedge clk);
        bus.c_valid = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        bus.m_ready = 1'b0;
        check("clr_m_valid", 64'(bus.m_valid), 64'd0);
        check("clr_busy", 64'(busy), 64'd0);
        check("clr_flag", 64'(err_overrun), 64'd0);
        load_frame(0, N - 1);
        pulse_done();
        check("clr_mask_busy", 64'(busy), 64'd0);
        check("clr_mask_incomplete", 64'(err_incomplete), 64'd1);
        do_clr();

        // Asynchronous reset mid-drain.
        load_frame(0, N);
        pulse_done();
        bus.m_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("rst_mid");
        bus.m_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Recovery after reset.
        load_frame(0, N);
        push_frame();
        pulse_done();
        run_drain(0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
